instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
// Inverse of the control-unit decode path: packs instruction fields (op, func, rs, rt, rd, imm, target)
// into 32-bit iZero words and writes them sequentially into instruction memory (loader/bootloader side).
// Validates op/func against the ISA opcode map; illegal fields are rejected with an error pulse, never written.
// Sits between the program source (switch/serial front end) and the instruction-memory write port.
// PARAMETERS
// ADDR_W   10   instruction-memory address width; last writable address = 2**ADDR_W-1
// PORTS
// clock      in   1       system clock, rising edge
// reset      in   1       asynchronous, active-low reset
// start      in   1       arm loader; samples base_addr (ignored unless IDLE)
// base_addr  in   ADDR_W  first write address
// finish     in   1       end of program; RUN -> IDLE
// in_valid   in   1       field bundle valid
// in_ready   out  1       = (state==RUN) & ~finish; transfer when in_valid & in_ready
// kind       in   2       0=R, 1=I, 2=J, 3=illegal
// op         in   6       opcode
// func       in   6       R-type function
// rs,rt,rd   in   5 each  register fields
// imm        in   16      I-type immediate
// target     in   26      J-type target
// im_write   out  1       instruction-memory write strobe (1 cycle)
// im_addr    out  ADDR_W  write address
// im_data    out  32      encoded word
// err        out  1       1-cycle pulse: bundle rejected
// done       out  1       1-cycle pulse: load ended (finish, halt or full)
// full       out  1       level: last address written, loader stopped
// word_count out  ADDR_W+1 words written since start
// BEHAVIOUR
// - Reset: state IDLE; in_ready, im_write, err, done, full = 0; im_addr, im_data, word_count = 0.
// - States: IDLE, RUN, WRITE.
// - IDLE: start -> latch im_addr=base_addr, word_count=0, full=0, go RUN.
// - RUN: finish -> done=1, go IDLE (finish has priority over in_valid; nothing accepted).
//   Transfer, legal -> latch im_data, go WRITE. Transfer, illegal -> err=1 next cycle, stay RUN.
// - WRITE: im_write=1 exactly one cycle at im_addr. On exit, word_count += 1 and:
//   op==24 (halt) -> done=1, IDLE; im_addr==2**ADDR_W-1 -> full=1, done=1, IDLE (no wrap);
//   else im_addr += 1, RUN.
// - Latency: transfer in cycle N -> im_write in cycle N+1; max throughput 1 word / 2 cycles.
// - Legality: R: op==0 and func 0..18. I: op 1..21, 25, 26 or 28. J: op 22, 23 or 24.
//   kind==3, or op/kind mismatch -> illegal.
// - Encoding: R = {6'd0, rs, rt, rd, 5'd0, func}; I = {op, rs, rt, imm}; J = {op, target}.
// - im_data and im_addr hold their values outside WRITE. full clears only on the next start.
// - start outside IDLE is ignored. Reset asserted mid-WRITE aborts the write asynchronously (im_write -> 0).
// TESTING
// 1) start, base=0x010; R add rs=1 rt=2 rd=3 -> im_write at 0x010, data 0x00221800, count=1.
// 2) I addi op=1 rs=4 rt=5 imm=0xFFFF, then J jal target=0x40 -> 0x0485FFFF @base, 0x5C000040 @base+1.
// 3) R func=19, I op=22, kind=3 -> err pulse each, no im_write, im_addr/count unchanged.
// 4) J halt op=24 -> written, then done=1, state IDLE, in_ready=0; next in_valid ignored.
// 5) base=2**ADDR_W-2; two legal words -> both written, full=1, done=1; third valid not accepted.
// 6) finish and in_valid in same RUN cycle -> in_ready=0, no write, done=1; reset low mid-WRITE -> all outputs 0.

Source files
------------

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_encoder
// Description : Loader-side instruction packer. Validates op/func/kind field
//               bundles against the ISA opcode map, packs legal bundles into
//               32-bit words and writes them sequentially into instruction
//               memory. Illegal bundles raise a one-cycle error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_finish,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_kind,
  input  logic [5:0]        i_op,
  input  logic [5:0]        i_func,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [15:0]       i_imm,
  input  logic [25:0]       i_target,
  output logic              o_im_write,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [31:0]       o_im_data,
  output logic              o_err,
  output logic              o_done,
  output logic              o_full,
  output logic [ADDR_W:0]   o_word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [5:0]        OP_HALT   = 6'd24;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_im_addr;
  logic [31:0]         r_im_data;
  logic                r_err;
  logic                r_done;
  logic                r_full;
  logic [ADDR_W:0]     r_word_count;
  logic                w_transfer;
  logic                w_legal;
  logic [31:0]         w_word;
  logic                w_halt;
  logic                w_last;

  // finish blocks acceptance in the same cycle so it always wins over data
  assign o_in_ready = (r_state == S_RUN) && !i_finish;
  assign w_transfer = i_in_valid && o_in_ready;
  // the strobe is decoded from state so an async reset drops it immediately
  assign o_im_write = (r_state == S_WRITE);
  // halt is recognised from the word already latched for writing
  assign w_halt     = (r_im_data[31:26] == OP_HALT);
  assign w_last     = (r_im_addr == LAST_ADDR);

  assign o_im_addr    = r_im_addr;
  assign o_im_data    = r_im_data;
  assign o_err        = r_err;
  assign o_done       = r_done;
  assign o_full       = r_full;
  assign o_word_count = r_word_count;

  // Field legality check and word packing for the incoming bundle
  always_comb begin
    w_legal = 1'b0;
    w_word  = 32'd0;
    case (i_kind)
      2'd0: begin
        w_legal = (i_op == 6'd0) && (i_func <= 6'd18);
        w_word  = {6'd0, i_rs, i_rt, i_rd, 5'd0, i_func};
      end
      2'd1: begin
        w_legal = ((i_op >= 6'd1) && (i_op <= 6'd21)) ||
                  (i_op == 6'd25) || (i_op == 6'd26) || (i_op == 6'd28);
        w_word  = {i_op, i_rs, i_rt, i_imm};
      end
      2'd2: begin
        w_legal = (i_op == 6'd22) || (i_op == 6'd23) || (i_op == 6'd24);
        w_word  = {i_op, i_target};
      end
      default: begin
        w_legal = 1'b0;
        w_word  = 32'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (i_finish) begin
          w_next = S_IDLE;
        end else if (w_transfer && w_legal) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_halt || w_last) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: address/data/count registers and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_im_addr    <= '0;
      r_im_data    <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_full       <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_im_addr    <= i_base_addr;
            r_word_count <= '0;
            r_full       <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_finish) begin
            r_done <= 1'b1;
          end else if (w_transfer) begin
            if (w_legal) begin
              r_im_data <= w_word;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_word_count <= r_word_count + (ADDR_W+1)'(1);
          if (w_halt) begin
            r_done <= 1'b1;
          end else if (w_last) begin
            // no wrap: park on the last address and report full
            r_full <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_im_addr <= r_im_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instruction_encoder
// Description : Self-checking bench for instruction_encoder using a table of
//               field bundles with hand-computed words plus directed sequences
//               for halt, full, finish and mid-write reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_finish;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [1:0]        i_kind;
  logic [5:0]        i_op;
  logic [5:0]        i_func;
  logic [4:0]        i_rs;
  logic [4:0]        i_rt;
  logic [4:0]        i_rd;
  logic [15:0]       i_imm;
  logic [25:0]       i_target;
  logic              o_im_write;
  logic [ADDR_W-1:0] o_im_addr;
  logic [31:0]       o_im_data;
  logic              o_err;
  logic              o_done;
  logic              o_full;
  logic [ADDR_W:0]   o_word_count;

  instruction_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_finish     (i_finish),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_kind       (i_kind),
    .i_op         (i_op),
    .i_func       (i_func),
    .i_rs         (i_rs),
    .i_rt         (i_rt),
    .i_rd         (i_rd),
    .i_imm        (i_imm),
    .i_target     (i_target),
    .o_im_write   (o_im_write),
    .o_im_addr    (o_im_addr),
    .o_im_data    (o_im_data),
    .o_err        (o_err),
    .o_done       (o_done),
    .o_full       (o_full),
    .o_word_count (o_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        legal;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W:0]   exp_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] k, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [15:0] imm, input logic [25:0] tg,
                              input logic lg, input logic [31:0] d);
    vec_t v;
    v.kind = k; v.op = op; v.func = fn; v.rs = rs; v.rt = rt; v.rd = rd;
    v.imm = imm; v.target = tg; v.legal = lg; v.data = d;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_kind = v.kind; i_op = v.op; i_func = v.func;
    i_rs = v.rs; i_rt = v.rt; i_rd = v.rd;
    i_imm = v.imm; i_target = v.target;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    i_in_valid = 1'b1;
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    i_base_addr = base;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    //               kind   op     func   rs     rt     rd     imm        target        legal  data
    vecs[0]  = mk(2'd0, 6'd0,  6'd0,  5'd1,  5'd2,  5'd3,  16'h0,    26'h0,       1'b1, 32'h00221800);
    vecs[1]  = mk(2'd1, 6'd1,  6'd0,  5'd4,  5'd5,  5'd0,  16'hFFFF, 26'h0,       1'b1, 32'h0485FFFF);
    vecs[2]  = mk(2'd2, 6'd23, 6'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h40,      1'b1, 32'h5C000040);
    vecs[3]  = mk(2'd0, 6'd0,  6'd19, 5'd1,  5'd1,  5'd1,  16'h0,    26'h0,       1'b0, 32'h0);
    vecs[4]  = mk(2'd1, 6'd22, 6'd0,  5'd1,  5'd1,  5'd0,  16'h1,    26'h0,       1'b0, 32'h0);
    vecs[5]  = mk(2'd3, 6'd0,  6'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h0,       1'b0, 32'h0);
    vecs[6]  = mk(2'd0, 6'd0,  6'd18, 5'd31, 5'd0,  5'd31, 16'h0,    26'h0,       1'b1, 32'h03E0F812);
    vecs[7]  = mk(2'd1, 6'd28, 6'd0,  5'd0,  5'd31, 5'd0,  16'h1234, 26'h0,       1'b1, 32'h701F1234);
    vecs[8]  = mk(2'd2, 6'd22, 6'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h3FFFFFF, 1'b1, 32'h5BFFFFFF);
    vecs[9]  = mk(2'd1, 6'd25, 6'd0,  5'd1,  5'd1,  5'd0,  16'h0,    26'h0,       1'b1, 32'h64210000);
    vecs[10] = mk(2'd0, 6'd1,  6'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h0,       1'b0, 32'h0);
    vecs[11] = mk(2'd1, 6'd24, 6'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h0,       1'b0, 32'h0);
    vecs[12] = mk(2'd2, 6'd21, 6'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h0,       1'b0, 32'h0);

    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_finish = 1'b0; i_in_valid = 1'b0;
    drive(vecs[0]);
    tick(); tick();
    chk("reset_in_ready", 32'(o_in_ready), 32'd0);
    chk("reset_im_write", 32'(o_im_write), 32'd0);
    chk("reset_outputs",  {o_err, o_done, o_full}, 32'd0);
    chk("reset_addr",     32'(o_im_addr), 32'd0);
    chk("reset_data",     o_im_data, 32'd0);
    chk("reset_count",    32'(o_word_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // table-driven run starting at 0x010
    do_start(10'h010);
    exp_addr = 10'h010; exp_count = '0;
    chk("start_addr",  32'(o_im_addr), 32'(exp_addr));
    chk("start_count", 32'(o_word_count), 32'd0);
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_ready", i), 32'(o_in_ready), 32'd1);
      send(vecs[i]);
      if (vecs[i].legal) begin
        chk($sformatf("v%0d_write", i), 32'(o_im_write), 32'd1);
        chk($sformatf("v%0d_addr", i),  32'(o_im_addr), 32'(exp_addr));
        chk($sformatf("v%0d_data", i),  o_im_data, vecs[i].data);
        chk($sformatf("v%0d_noerr", i), 32'(o_err), 32'd0);
        tick();
        exp_addr++; exp_count++;
        chk($sformatf("v%0d_wr_end", i), 32'(o_im_write), 32'd0);
        chk($sformatf("v%0d_count", i),  32'(o_word_count), 32'(exp_count));
        chk($sformatf("v%0d_next", i),   32'(o_im_addr), 32'(exp_addr));
      end else begin
        chk($sformatf("v%0d_err", i),    32'(o_err), 32'd1);
        chk($sformatf("v%0d_nowr", i),   32'(o_im_write), 32'd0);
        chk($sformatf("v%0d_addr", i),   32'(o_im_addr), 32'(exp_addr));
        chk($sformatf("v%0d_count", i),  32'(o_word_count), 32'(exp_count));
        tick();
        chk($sformatf("v%0d_err_end", i), 32'(o_err), 32'd0);
      end
    end

    // start while running must be ignored
    do_start(10'h3AA);
    chk("start_ignored_addr",  32'(o_im_addr), 32'(exp_addr));
    chk("start_ignored_count", 32'(o_word_count), 32'(exp_count));

    // halt: written, then done and back to idle
    send(mk(2'd2, 6'd24, 6'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'h60000000));
    chk("halt_write", 32'(o_im_write), 32'd1);
    chk("halt_data",  o_im_data, 32'h60000000);
    chk("halt_addr",  32'(o_im_addr), 32'(exp_addr));
    tick();
    exp_count++;
    chk("halt_done",  32'(o_done), 32'd1);
    chk("halt_ready", 32'(o_in_ready), 32'd0);
    chk("halt_count", 32'(o_word_count), 32'(exp_count));
    send(vecs[0]);
    chk("post_halt_nowr",  32'(o_im_write), 32'd0);
    chk("post_halt_done0", 32'(o_done), 32'd0);
    chk("post_halt_count", 32'(o_word_count), 32'(exp_count));

    // fill to the last address: no wrap, full level
    do_start(10'h3FE);
    chk("full_start_count", 32'(o_word_count), 32'd0);
    chk("full_start_addr",  32'(o_im_addr), 32'h3FE);
    send(vecs[1]);
    chk("full_w1_write", 32'(o_im_write), 32'd1);
    chk("full_w1_addr",  32'(o_im_addr), 32'h3FE);
    tick();
    chk("full_w1_notfull", 32'(o_full), 32'd0);
    send(vecs[2]);
    chk("full_w2_write", 32'(o_im_write), 32'd1);
    chk("full_w2_addr",  32'(o_im_addr), 32'h3FF);
    chk("full_w2_data",  o_im_data, 32'h5C000040);
    tick();
    chk("full_flag",   32'(o_full), 32'd1);
    chk("full_done",   32'(o_done), 32'd1);
    chk("full_count",  32'(o_word_count), 32'd2);
    chk("full_nowrap", 32'(o_im_addr), 32'h3FF);
    i_in_valid = 1'b1;
    #1;
    chk("full_ready", 32'(o_in_ready), 32'd0);
    tick();
    i_in_valid = 1'b0;
    chk("full_third_nowr", 32'(o_im_write), 32'd0);
    chk("full_level",      32'(o_full), 32'd1);
    do_start(10'h020);
    chk("full_cleared", 32'(o_full), 32'd0);

    // finish beats in_valid in the same RUN cycle
    drive(vecs[0]);
    i_finish = 1'b1; i_in_valid = 1'b1;
    #1;
    chk("finish_ready", 32'(o_in_ready), 32'd0);
    tick();
    chk("finish_done",  32'(o_done), 32'd1);
    chk("finish_nowr",  32'(o_im_write), 32'd0);
    chk("finish_count", 32'(o_word_count), 32'd0);
    i_finish = 1'b0; i_in_valid = 1'b0;
    tick();
    chk("finish_done_end", 32'(o_done), 32'd0);
    chk("finish_idle",     32'(o_in_ready), 32'd0);

    // async reset during WRITE aborts the strobe
    do_start(10'h030);
    send(vecs[7]);
    chk("rst_pre_write", 32'(o_im_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_write", 32'(o_im_write), 32'd0);
    chk("rst_addr",  32'(o_im_addr), 32'd0);
    chk("rst_data",  o_im_data, 32'd0);
    chk("rst_count", 32'(o_word_count), 32'd0);
    chk("rst_flags", {o_in_ready, o_err, o_done, o_full}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
